// File: rtl/epu_pool_pkg.sv
// Shared types and constants for the 2x2 max-pool / flatten stage.
// Parameter word map, SRAM write-enable encoding, FSM states and int8 helpers.
package epu_pool_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DIM_W  = 6;
  localparam int CH_W   = 7;

  localparam logic WRITE_ENB = 1'b1;
  localparam logic WRITE_DIS = 1'b0;

  localparam logic [1:0] PRM_H    = 2'd0;
  localparam logic [1:0] PRM_W    = 2'd1;
  localparam logic [1:0] PRM_C    = 2'd2;
  localparam logic [1:0] PRM_FLAG = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_PARAM = 3'd1,
    ST_CHECK      = 3'd2,
    ST_READ       = 3'd3,
    ST_CMP        = 3'd4,
    ST_WRITE      = 3'd5,
    ST_FINISH     = 3'd6
  } pool_state_t;

  function automatic logic signed [7:0] max_s8(input logic signed [7:0] a,
                                               input logic signed [7:0] b);
    return (b > a) ? b : a;
  endfunction

  function automatic logic [7:0] relu_s8(input logic signed [7:0] v, input logic en);
    return (en && (v < 8'sd0)) ? 8'h00 : v;
  endfunction

endpackage

// File: rtl/maxpool_flatten_if.sv
// SRAM-side and control signals of the max-pool stage.
// master = the pooling engine, slave = controller / SRAM environment.
interface maxpool_flatten_if;
  import epu_pool_pkg::*;

  logic              start;
  logic              finish;
  logic              prm_cs;
  logic [ADDR_W-1:0] prm_addr;
  logic [DATA_W-1:0] prm_rdata;
  logic              fm_cs;
  logic [ADDR_W-1:0] fm_addr;
  logic [DATA_W-1:0] fm_rdata;
  logic              out_cs;
  logic              out_w_req;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_wdata;

  modport master (
    input  start, prm_rdata, fm_rdata,
    output finish, prm_cs, prm_addr, fm_cs, fm_addr,
           out_cs, out_w_req, out_addr, out_wdata
  );

  modport slave (
    output start, prm_rdata, fm_rdata,
    input  finish, prm_cs, prm_addr, fm_cs, fm_addr,
           out_cs, out_w_req, out_addr, out_wdata
  );

endinterface

// File: rtl/pool_addr_gen.sv
// Output-coordinate counters and incremental feature-map / flattened-output addressing.
// Row and channel bases advance by additions only; odd trailing rows/cols are skipped.
module pool_addr_gen
  import epu_pool_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              rd_step,
  input  logic              adv,
  input  logic [1:0]        k,
  input  logic [DIM_W-1:0]  h,
  input  logic [DIM_W-1:0]  w,
  input  logic [CH_W-1:0]   c_num,
  output logic [ADDR_W-1:0] fm_addr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              last
);

  logic [DIM_W-1:0]  x_r, y_r;
  logic [CH_W-1:0]   c_r;
  logic [ADDR_W-1:0] row_r, base_r, fm_addr_r, out_addr_r;

  logic [DIM_W-1:0]  ho_s, wo_s;
  logic [ADDR_W-1:0] w_s, row_nx_s, chan_nx_s, rd_inc_s;
  logic              x_last_s, y_last_s, c_last_s;

  assign ho_s      = {1'b0, h[DIM_W-1:1]};
  assign wo_s      = {1'b0, w[DIM_W-1:1]};
  assign w_s       = ADDR_W'(w);
  assign x_last_s  = (x_r == (wo_s - DIM_W'(1)));
  assign y_last_s  = (y_r == (ho_s - DIM_W'(1)));
  assign c_last_s  = (c_r == (c_num - CH_W'(1)));
  assign last      = x_last_s & y_last_s & c_last_s;

  // Next row pair skips two rows; next channel also skips a dropped odd row.
  assign row_nx_s  = row_r + (w_s << 1);
  assign chan_nx_s = row_nx_s + (h[0] ? w_s : '0);
  // Window walk: p -> p+1 -> p+W -> p+W+1.
  assign rd_inc_s  = (k == 2'd1) ? (w_s - ADDR_W'(1)) : ADDR_W'(1);

  assign fm_addr   = fm_addr_r;
  assign out_addr  = out_addr_r;

  // Counter and pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_r        <= '0;
      y_r        <= '0;
      c_r        <= '0;
      row_r      <= '0;
      base_r     <= '0;
      fm_addr_r  <= '0;
      out_addr_r <= '0;
    end else if (clr) begin
      x_r        <= '0;
      y_r        <= '0;
      c_r        <= '0;
      row_r      <= '0;
      base_r     <= '0;
      fm_addr_r  <= '0;
      out_addr_r <= '0;
    end else if (adv) begin
      out_addr_r <= out_addr_r + ADDR_W'(1);
      if (!x_last_s) begin
        x_r       <= x_r + DIM_W'(1);
        base_r    <= base_r + ADDR_W'(2);
        fm_addr_r <= base_r + ADDR_W'(2);
      end else if (!y_last_s) begin
        x_r       <= '0;
        y_r       <= y_r + DIM_W'(1);
        row_r     <= row_nx_s;
        base_r    <= row_nx_s;
        fm_addr_r <= row_nx_s;
      end else begin
        x_r       <= '0;
        y_r       <= '0;
        c_r       <= c_r + CH_W'(1);
        row_r     <= chan_nx_s;
        base_r    <= chan_nx_s;
        fm_addr_r <= chan_nx_s;
      end
    end else if (rd_step) begin
      fm_addr_r <= fm_addr_r + rd_inc_s;
    end else begin
      fm_addr_r <= fm_addr_r;
    end
  end

endmodule

// File: rtl/maxpool_flatten.sv
// 2x2/stride-2 int8 max-pool with optional ReLU, flattening CxHxW into the FC input SRAM.
// Holds the sequencing FSM, running max, ReLU and all registered SRAM drives.
module maxpool_flatten
  import epu_pool_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  maxpool_flatten_if.master  bus
);

  pool_state_t state_r, state_nx;
  logic [2:0]  cnt_r, cnt_nx;

  logic [DIM_W-1:0]  h_r, w_r;
  logic [CH_W-1:0]   c_r;
  logic              relu_r;
  logic signed [7:0] max_r;

  logic              finish_r, prm_cs_r, fm_cs_r, out_cs_r, out_w_req_r;
  logic [ADDR_W-1:0] prm_addr_r;
  logic [DATA_W-1:0] out_wdata_r;

  logic signed [7:0] pix_s;
  logic [2:0]        cap_idx_s;
  logic              degenerate_s, last_s, clr_s, adv_s, rd_step_s, prm_issue_s;
  logic [ADDR_W-1:0] fm_addr_s, out_addr_s;
  logic              unused_s;

  assign pix_s        = bus.fm_rdata[7:0];
  assign cap_idx_s    = cnt_r - 3'd1;
  assign degenerate_s = (h_r[DIM_W-1:1] == '0) || (w_r[DIM_W-1:1] == '0) || (c_r == '0);
  assign unused_s     = ^{bus.prm_rdata[DATA_W-1:CH_W], bus.fm_rdata[DATA_W-1:8]};

  assign clr_s       = (state_r == ST_IDLE) || (state_r == ST_LOAD_PARAM) ||
                       (state_r == ST_CHECK) || (state_r == ST_FINISH) ||
                       ((state_r == ST_WRITE) && last_s);
  assign adv_s       = (state_r == ST_WRITE) && !last_s;
  assign rd_step_s   = (state_r == ST_READ) && (cnt_r != 3'd3);
  assign prm_issue_s = (state_nx == ST_LOAD_PARAM) && (cnt_nx < 3'd4);

  pool_addr_gen u_addr_gen (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (clr_s),
    .rd_step  (rd_step_s),
    .adv      (adv_s),
    .k        (cnt_r[1:0]),
    .h        (h_r),
    .w        (w_r),
    .c_num    (c_r),
    .fm_addr  (fm_addr_s),
    .out_addr (out_addr_s),
    .last     (last_s)
  );

  // FSM state and phase counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
    end
  end

  // Next-state logic; cnt is the param-load step or the pixel index k.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx = ST_LOAD_PARAM;
          cnt_nx   = 3'd0;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_LOAD_PARAM: begin
        if (cnt_r == 3'd4) begin
          state_nx = ST_CHECK;
          cnt_nx   = 3'd0;
        end else begin
          cnt_nx = cnt_r + 3'd1;
        end
      end
      ST_CHECK: begin
        cnt_nx   = 3'd0;
        state_nx = degenerate_s ? ST_FINISH : ST_READ;
      end
      ST_READ: begin
        if (cnt_r == 3'd3) begin
          state_nx = ST_CMP;
          cnt_nx   = 3'd0;
        end else begin
          cnt_nx = cnt_r + 3'd1;
        end
      end
      ST_CMP:    state_nx = ST_WRITE;
      ST_WRITE: begin
        cnt_nx   = 3'd0;
        state_nx = last_s ? ST_FINISH : ST_READ;
      end
      ST_FINISH: state_nx = ST_IDLE;
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = 3'd0;
      end
    endcase
  end

  // Parameter capture lags the issued address by one cycle; running max over k.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_r    <= '0;
      w_r    <= '0;
      c_r    <= '0;
      relu_r <= 1'b0;
      max_r  <= 8'sd0;
    end else begin
      if (state_r == ST_LOAD_PARAM) begin
        case (cap_idx_s)
          3'(PRM_H):    h_r    <= bus.prm_rdata[DIM_W-1:0];
          3'(PRM_W):    w_r    <= bus.prm_rdata[DIM_W-1:0];
          3'(PRM_C):    c_r    <= bus.prm_rdata[CH_W-1:0];
          3'(PRM_FLAG): relu_r <= bus.prm_rdata[0];
          default:      relu_r <= relu_r;
        endcase
      end
      if (state_r == ST_READ) begin
        case (cnt_r)
          3'd1:        max_r <= pix_s;
          3'd2, 3'd3:  max_r <= max_s8(max_r, pix_s);
          default:     max_r <= max_r;
        endcase
      end
    end
  end

  // Registered SRAM drives, decoded from the state being entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      finish_r    <= 1'b0;
      prm_cs_r    <= 1'b0;
      prm_addr_r  <= '0;
      fm_cs_r     <= 1'b0;
      out_cs_r    <= 1'b0;
      out_w_req_r <= WRITE_DIS;
      out_wdata_r <= '0;
    end else begin
      finish_r    <= (state_nx == ST_FINISH);
      prm_cs_r    <= prm_issue_s;
      prm_addr_r  <= prm_issue_s ? ADDR_W'(cnt_nx) : '0;
      fm_cs_r     <= (state_nx == ST_READ);
      out_cs_r    <= (state_nx == ST_WRITE);
      out_w_req_r <= (state_nx == ST_WRITE) ? WRITE_ENB : WRITE_DIS;
      out_wdata_r <= (state_r == ST_CMP) ?
                     {{(DATA_W-8){1'b0}}, relu_s8(max_s8(max_r, pix_s), relu_r)} : '0;
    end
  end

  assign bus.finish    = finish_r;
  assign bus.prm_cs    = prm_cs_r;
  assign bus.prm_addr  = prm_addr_r;
  assign bus.fm_cs     = fm_cs_r;
  assign bus.fm_addr   = fm_addr_s;
  assign bus.out_cs    = out_cs_r;
  assign bus.out_w_req = out_w_req_r;
  assign bus.out_addr  = out_addr_s;
  assign bus.out_wdata = out_wdata_r;

endmodule

// File: tb/tb_maxpool_flatten.sv
// Bench for maxpool_flatten: SRAM models, a pooling reference model and a per-cycle
// compare process, plus directed runs with hand-computed expectations.
module tb_maxpool_flatten;
  import epu_pool_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  maxpool_flatten_if bus ();
  maxpool_flatten dut (.clk(clk), .rstn(rstn), .bus(bus));

  logic [DATA_W-1:0] prm_mem [4];
  logic signed [7:0] fm_mem  [256];
  logic [7:0]        out_mem [256];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int fm_reads = 0;
  logic [31:0] exp_rd_q [$];
  logic [31:0] exp_wa_q [$];
  logic [31:0] exp_wd_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: read data valid the cycle after cs/addr.
  always @(posedge clk) begin
    if (bus.prm_cs) bus.prm_rdata <= prm_mem[bus.prm_addr[1:0]];
    if (bus.fm_cs) bus.fm_rdata <= {24'h0, fm_mem[bus.fm_addr[7:0]]};
    if (bus.out_cs && (bus.out_w_req == WRITE_ENB)) out_mem[bus.out_addr[7:0]] <= bus.out_wdata[7:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: every output is the max of its 2x2 window, addressed directly from (c,y,x).
  task automatic model(input int h, input int w, input int c, input int relu);
    int ho, wo, a;
    logic signed [7:0] m, p;
    ho = h / 2;
    wo = w / 2;
    m  = 8'sd0;
    prm_mem[0] = 32'(h);
    prm_mem[1] = 32'(w);
    prm_mem[2] = 32'(c);
    prm_mem[3] = 32'(relu);
    for (int ch = 0; ch < c; ch++)
      for (int y = 0; y < ho; y++)
        for (int x = 0; x < wo; x++) begin
          for (int k = 0; k < 4; k++) begin
            a = ch * h * w + (2 * y + k / 2) * w + 2 * x + k % 2;
            exp_rd_q.push_back(32'(a));
            p = fm_mem[a];
            if (k == 0 || p > m) m = p;
          end
          if (relu != 0 && m < 0) m = 8'sd0;
          exp_wa_q.push_back(32'((ch * ho + y) * wo + x));
          exp_wd_q.push_back({24'h0, m});
        end
  endtask

  task automatic prep();
    for (int i = 0; i < 256; i++) begin
      fm_mem[i]  = 8'sd0;
      out_mem[i] = 8'hAA;
    end
    fm_reads = 0;
  endtask

  task automatic wait_fin(input int exp_cyc, input string name);
    int n;
    n = 0;
    while (!bus.finish && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_finish_seen"}, 32'(bus.finish), 32'd1);
    check({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic run(input int lat, input string name);
    int t0;
    @(negedge clk);
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    wait_fin(t0 + lat, name);
    @(negedge clk);
    check({name, "_finish_pulse"}, 32'(bus.finish), 32'd0);
    check({name, "_writes_done"}, 32'(exp_wa_q.size()), 32'd0);
    check({name, "_reads_done"}, 32'(exp_rd_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_finish"}, 32'(bus.finish), 32'd0);
    check({name, "_prm_cs"}, 32'(bus.prm_cs), 32'd0);
    check({name, "_fm_cs"}, 32'(bus.fm_cs), 32'd0);
    check({name, "_out_cs"}, 32'(bus.out_cs), 32'd0);
    check({name, "_w_req"}, 32'(bus.out_w_req), 32'(WRITE_DIS));
    check({name, "_prm_addr"}, bus.prm_addr, 32'd0);
    check({name, "_fm_addr"}, bus.fm_addr, 32'd0);
    check({name, "_out_addr"}, bus.out_addr, 32'd0);
    check({name, "_wdata"}, bus.out_wdata, 32'd0);
  endtask

  // Compare process: every read and write is checked against the model queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.out_w_req == WRITE_ENB) begin
          check("wr_cs", 32'(bus.out_cs), 32'd1);
          if (exp_wa_q.size() == 0) check("wr_unexpected", bus.out_addr, 32'hFFFF_FFFF);
          else begin
            check("wr_addr", bus.out_addr, exp_wa_q.pop_front());
            check("wr_data", bus.out_wdata, exp_wd_q.pop_front());
          end
        end
        if (bus.fm_cs) begin
          fm_reads++;
          if (exp_rd_q.size() == 0) check("rd_unexpected", bus.fm_addr, 32'hFFFF_FFFF);
          else check("rd_addr", bus.fm_addr, exp_rd_q.pop_front());
        end
        if (bus.prm_cs || bus.fm_cs || bus.out_cs)
          check("cs_exclusive", 32'(int'(bus.prm_cs) + int'(bus.fm_cs) + int'(bus.out_cs)), 32'd1);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, wr, t0;
    bus.start     = 1'b0;
    bus.prm_rdata = '0;
    bus.fm_rdata  = '0;
    prep();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    // 4x4x1 ramp
    prep();
    for (int i = 0; i < 16; i++) fm_mem[i] = 8'(i);
    model(4, 4, 1, 0);
    run(31, "t4x4");
    check("t4x4_o0", 32'(out_mem[0]), 32'd5);
    check("t4x4_o1", 32'(out_mem[1]), 32'd7);
    check("t4x4_o2", 32'(out_mem[2]), 32'd13);
    check("t4x4_o3", 32'(out_mem[3]), 32'd15);
    check("t4x4_reads", 32'(fm_reads), 32'd16);

    // 5x5x2, odd dims: row 4 / col 4 never read
    prep();
    for (int i = 0; i < 25; i++) begin
      fm_mem[i]      = 8'(i);
      fm_mem[25 + i] = 8'(-i);
    end
    model(5, 5, 2, 0);
    run(55, "t5x5");
    check("t5x5_o0", 32'(out_mem[0]), 32'd6);
    check("t5x5_o3", 32'(out_mem[3]), 32'd18);
    check("t5x5_o4", 32'(out_mem[4]), 32'h00);
    check("t5x5_o5", 32'(out_mem[5]), 32'hFE);
    check("t5x5_o6", 32'(out_mem[6]), 32'hF6);
    check("t5x5_o7", 32'(out_mem[7]), 32'hF4);
    check("t5x5_reads", 32'(fm_reads), 32'd32);

    // 2x2 all-negative, with and without ReLU
    prep();
    fm_mem[0] = -8'sd5; fm_mem[1] = -8'sd3; fm_mem[2] = -8'sd8; fm_mem[3] = -8'sd1;
    model(2, 2, 1, 1);
    run(13, "t2x2_relu");
    check("t2x2_relu_o0", 32'(out_mem[0]), 32'h00);
    out_mem[0] = 8'hAA;
    model(2, 2, 1, 0);
    run(13, "t2x2_norelu");
    check("t2x2_norelu_o0", 32'(out_mem[0]), 32'hFF);

    // Degenerate: Ho == 0
    prep();
    model(1, 8, 4, 0);
    run(7, "tdegen");
    check("tdegen_reads", 32'(fm_reads), 32'd0);
    check("tdegen_no_write", 32'(out_mem[0]), 32'hAA);

    // Reset during the 3rd WRITE of a 4x4x2 run, then a clean rerun
    prep();
    for (int i = 0; i < 32; i++) fm_mem[i] = 8'(i);
    model(4, 4, 2, 0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n  = 0;
    wr = 0;
    while (wr < 3 && n < 2000) begin
      @(negedge clk);
      n++;
      if (bus.out_w_req == WRITE_ENB) wr++;
    end
    check("abort_third_write", 32'(wr), 32'd3);
    #1 rstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    check("abort_no_wreq", 32'(bus.out_w_req), 32'(WRITE_DIS));
    check("abort_o1_kept", 32'(out_mem[1]), 32'd7);
    check("abort_o2_suppressed", 32'(out_mem[2]), 32'hAA);
    exp_rd_q.delete();
    exp_wa_q.delete();
    exp_wd_q.delete();
    rstn = 1'b1;
    @(negedge clk);
    model(4, 4, 2, 0);
    run(55, "trestart");
    check("trestart_o2", 32'(out_mem[2]), 32'd13);
    check("trestart_o4", 32'(out_mem[4]), 32'd21);
    check("trestart_o7", 32'(out_mem[7]), 32'd31);

    // Back-to-back runs with start held high
    prep();
    fm_mem[0] = 8'sd1; fm_mem[1] = 8'sd9; fm_mem[2] = 8'sd4; fm_mem[3] = 8'sd2;
    model(2, 2, 1, 0);
    model(2, 2, 1, 0);
    @(negedge clk);
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    wait_fin(t0 + 13, "tb2b_first");
    check("tb2b_first_o0", 32'(out_mem[0]), 32'd9);
    out_mem[0] = 8'hAA;
    @(negedge clk);
    wait_fin(t0 + 27, "tb2b_second");
    bus.start = 1'b0;
    @(negedge clk);
    check("tb2b_finish_pulse", 32'(bus.finish), 32'd0);
    check("tb2b_second_o0", 32'(out_mem[0]), 32'd9);
    check("tb2b_reads", 32'(fm_reads), 32'd8);
    check("tb2b_writes_done", 32'(exp_wa_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
